// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator: detects the host start pulse on the single-wire bus and
// answers with the preamble, 40 data bits and the trailing low. The bus is only ever pulled low.
module dht11_emulador #(
  parameter int unsigned CICLOS_US      = 50,
  parameter int unsigned T_START_US     = 18000,
  parameter int unsigned T_ESPERA_US    = 30,
  parameter int unsigned T_RESP_US      = 80,
  parameter int unsigned T_BIT_BAIXO_US = 50,
  parameter int unsigned T_ZERO_US      = 27,
  parameter int unsigned T_UM_US        = 70
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        injeta_erro_checksum,
  input  logic        dht_in,
  output logic        dht_puxa_baixo,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int unsigned START_CYC  = T_START_US * CICLOS_US;
  localparam int unsigned ESPERA_CYC = T_ESPERA_US * CICLOS_US;
  localparam int unsigned RESP_CYC   = T_RESP_US * CICLOS_US;
  localparam int unsigned BAIXO_CYC  = T_BIT_BAIXO_US * CICLOS_US;
  localparam int unsigned ZERO_CYC   = T_ZERO_US * CICLOS_US;
  localparam int unsigned UM_CYC     = T_UM_US * CICLOS_US;

  localparam int unsigned MAX_A   = (START_CYC > RESP_CYC) ? START_CYC : RESP_CYC;
  localparam int unsigned MAX_B   = (MAX_A > UM_CYC) ? MAX_A : UM_CYC;
  localparam int unsigned MAX_C   = (MAX_B > BAIXO_CYC) ? MAX_B : BAIXO_CYC;
  localparam int unsigned MAX_CYC = (MAX_C > ESPERA_CYC) ? MAX_C : ESPERA_CYC;
  localparam int          W       = $clog2(MAX_CYC + 1);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESPERA_BAIXO = 4'd1,
    MEDE_START   = 4'd2,
    ATRASO       = 4'd3,
    RESP_BAIXO   = 4'd4,
    RESP_ALTO    = 4'd5,
    BIT_BAIXO    = 4'd6,
    BIT_ALTO     = 4'd7,
    FIM_BAIXO    = 4'd8,
    FIM          = 4'd9
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [39:0]    quadro_q, quadro_d;
  logic [5:0]     idx_q, idx_d;
  logic           ocupado_q, ocupado_d;
  logic [1:0]     sync_q;
  logic           dht_s;
  logic [W-1:0]   dur_m1;
  logic           fim_fase;
  logic [7:0]     soma;
  logic [7:0]     checksum;

  assign dht_s     = sync_q[1];
  assign soma      = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
  assign checksum  = soma ^ {7'b0, injeta_erro_checksum};
  assign ocupado   = ocupado_q;
  assign db_estado = estado_q;
  assign fim_fase  = (cnt_q == dur_m1);

  // Last count value of the current timed phase; the bit-high phase depends on the MSB in flight.
  always_comb begin
    dur_m1 = W'(ESPERA_CYC - 1);
    case (estado_q)
      RESP_BAIXO, RESP_ALTO: dur_m1 = W'(RESP_CYC - 1);
      BIT_BAIXO, FIM_BAIXO:  dur_m1 = W'(BAIXO_CYC - 1);
      BIT_ALTO:              dur_m1 = quadro_q[39] ? W'(UM_CYC - 1) : W'(ZERO_CYC - 1);
      default:               dur_m1 = W'(ESPERA_CYC - 1);
    endcase
  end

  always_comb begin
    estado_d       = estado_q;
    cnt_d          = cnt_q;
    quadro_d       = quadro_q;
    idx_d          = idx_q;
    ocupado_d      = ocupado_q;
    dht_puxa_baixo = 1'b0;
    pronto         = 1'b0;
    case (estado_q)
      INICIAL: estado_d = ESPERA_BAIXO;
      ESPERA_BAIXO: begin
        if (habilita && !dht_s) begin
          cnt_d    = '0;
          estado_d = MEDE_START;
        end
      end
      MEDE_START: begin
        // Counter saturates at the threshold so an arbitrarily long host low is still accepted.
        if (!dht_s) begin
          if (cnt_q != W'(START_CYC - 1)) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == W'(START_CYC - 1)) begin
          cnt_d     = '0;
          idx_d     = '0;
          ocupado_d = 1'b1;
          quadro_d  = {umidade, temperatura, checksum};
          estado_d  = ATRASO;
        end else begin
          estado_d = ESPERA_BAIXO;
        end
      end
      ATRASO: begin
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) estado_d = RESP_BAIXO;
      end
      RESP_BAIXO: begin
        dht_puxa_baixo = 1'b1;
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) estado_d = RESP_ALTO;
      end
      RESP_ALTO: begin
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) estado_d = BIT_BAIXO;
      end
      BIT_BAIXO: begin
        dht_puxa_baixo = 1'b1;
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) estado_d = BIT_ALTO;
      end
      BIT_ALTO: begin
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) begin
          quadro_d = {quadro_q[38:0], 1'b0};
          if (idx_q == 6'd39) begin
            estado_d = FIM_BAIXO;
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = BIT_BAIXO;
          end
        end
      end
      FIM_BAIXO: begin
        dht_puxa_baixo = 1'b1;
        cnt_d = fim_fase ? '0 : cnt_q + 1'b1;
        if (fim_fase) estado_d = FIM;
      end
      FIM: begin
        pronto    = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = ESPERA_BAIXO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      cnt_q     <= '0;
      quadro_q  <= '0;
      idx_q     <= '0;
      ocupado_q <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      quadro_q  <= quadro_d;
      idx_q     <= idx_d;
      ocupado_q <= ocupado_d;
      sync_q    <= {sync_q[0], dht_in};
    end
  end

endmodule

// File: tb/tb_dht11_emulador.sv
// Directed bench for dht11_emulador: a host model drives start pulses and the reply is
// decoded from the low/high run lengths seen on the wired bus.
module tb_dht11_emulador;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic [15:0] umidade;
  logic [15:0] temperatura;
  logic        injeta;
  logic        host_low;
  logic        dht_in;
  logic        puxa;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Open-drain bus with pull-up: either side pulling low wins.
  assign dht_in = ~(host_low | puxa);

  dht11_emulador #(
    .CICLOS_US(1), .T_START_US(18), .T_ESPERA_US(3), .T_RESP_US(8),
    .T_BIT_BAIXO_US(5), .T_ZERO_US(2), .T_UM_US(7)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita),
    .umidade(umidade), .temperatura(temperatura),
    .injeta_erro_checksum(injeta), .dht_in(dht_in),
    .dht_puxa_baixo(puxa), .ocupado(ocupado), .pronto(pronto),
    .db_estado(db_estado)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic host_start(input int n);
    @(negedge clock);
    host_low = 1'b1;
    repeat (n) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic observe(input int n, output int n_puxa, output int n_pronto, output int n_ocup);
    n_puxa = 0; n_pronto = 0; n_ocup = 0;
    repeat (n) begin
      @(negedge clock);
      if (puxa)    n_puxa++;
      if (pronto)  n_pronto++;
      if (ocupado) n_ocup++;
    end
  endtask

  // Records bus run lengths while ocupado is high and decodes them against the nominal timing:
  // 3 released, 8 low, 8 high, 40 x (5 low, 2|7 high), 5 low, 1 released (FIM).
  task automatic capture(input int bit_mudar, output logic [39:0] dados,
                         output bit forma_ok, output bit ocup_ok, output bit timeout);
    int   runs[$];
    bit   started;
    bit   done;
    logic lvl;
    int   len;
    int   n;
    started = 0; done = 0; lvl = 1'b0; len = 0; n = 0;
    dados = '0; forma_ok = 1; ocup_ok = 1;
    while (!done && n < 1500) begin
      @(negedge clock);
      n++;
      if (bit_mudar >= 0 && runs.size() == 3 + 2 * bit_mudar) temperatura = 16'hFFFF;
      if (ocupado) begin
        if (!started) begin
          started = 1; lvl = puxa; len = 1;
          if (puxa) forma_ok = 0;
        end else if (puxa == lvl) begin
          len++;
        end else begin
          runs.push_back(len); lvl = puxa; len = 1;
        end
      end else if (started) begin
        ocup_ok = 0;
      end
      if (pronto) begin
        done = 1;
        if (started) runs.push_back(len);
      end
    end
    timeout = !done;
    if (runs.size() != 85) begin
      forma_ok = 0;
    end else begin
      if (runs[0] != 3 || runs[1] != 8 || runs[2] != 8) forma_ok = 0;
      for (int i = 0; i < 40; i++) begin
        if (runs[3 + 2 * i] != 5) forma_ok = 0;
        if (runs[4 + 2 * i] == 7)      dados[39 - i] = 1'b1;
        else if (runs[4 + 2 * i] == 2) dados[39 - i] = 1'b0;
        else                           forma_ok = 0;
      end
      if (runs[83] != 5 || runs[84] != 1) forma_ok = 0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; habilita = 1'b1; injeta = 1'b0; host_low = 1'b0;
    umidade = 16'h0000; temperatura = 16'h0000;
    idle(3);
    checks++; if (puxa !== 1'b0)    $display("FAIL reset_puxa: got %b expected 0", puxa);       if (puxa !== 1'b0) errors++;
    checks++; if (ocupado !== 1'b0) begin $display("FAIL reset_ocupado: got %b expected 0", ocupado); errors++; end
    checks++; if (pronto !== 1'b0)  begin $display("FAIL reset_pronto: got %b expected 0", pronto); errors++; end
    checks++; if (db_estado !== 4'd0) begin $display("FAIL reset_estado: got %0d expected 0", db_estado); errors++; end
    reset = 1'b0;
    idle(3);
    checks++; if (db_estado !== 4'd1) begin $display("FAIL idle_estado: got %0d expected 1", db_estado); errors++; end
  endtask

  task automatic test_nominal;
    logic [39:0] d; bit fok, ook, to; int np, npr, noc;
    umidade = 16'h3C00; temperatura = 16'h1900; injeta = 1'b0;
    host_start(20);
    capture(-1, d, fok, ook, to);
    checks++; if (to || !fok) begin $display("FAIL nominal_timing: got timeout=%0d shape_ok=%0d expected timeout=0 shape_ok=1", to, fok); errors++; end
    checks++; if (d !== 40'h3C00_1900_55) begin $display("FAIL nominal_data: got %h expected 3c00190055", d); errors++; end
    checks++; if (!ook) begin $display("FAIL nominal_ocupado: got drop expected high throughout"); errors++; end
    observe(30, np, npr, noc);
    checks++; if (np != 0 || noc != 0) begin $display("FAIL nominal_release: got puxa=%0d ocupado=%0d cycles expected 0", np, noc); errors++; end
    checks++; if (npr != 0) begin $display("FAIL nominal_single_pronto: got %0d extra pulses expected 0", npr); errors++; end
  endtask

  task automatic test_short_start;
    int np, npr, noc;
    host_start(10);
    observe(60, np, npr, noc);
    checks++; if (np != 0) begin $display("FAIL short_puxa: got %0d expected 0", np); errors++; end
    checks++; if (npr != 0) begin $display("FAIL short_pronto: got %0d expected 0", npr); errors++; end
    checks++; if (noc != 0) begin $display("FAIL short_ocupado: got %0d expected 0", noc); errors++; end
    checks++; if (db_estado !== 4'd1) begin $display("FAIL short_estado: got %0d expected 1", db_estado); errors++; end
  endtask

  task automatic test_checksum;
    logic [39:0] d; bit fok, ook, to;
    umidade = 16'h5005; temperatura = 16'h1A03; injeta = 1'b1;
    host_start(20);
    capture(-1, d, fok, ook, to);
    checks++; if (to || !fok) begin $display("FAIL cks_err_timing: got timeout=%0d shape_ok=%0d expected 0/1", to, fok); errors++; end
    checks++; if (d !== 40'h5005_1A03_73) begin $display("FAIL cks_err_data: got %h expected 50051a0373", d); errors++; end
    idle(5);
    injeta = 1'b0;
    host_start(20);
    capture(-1, d, fok, ook, to);
    checks++; if (to || !fok) begin $display("FAIL cks_ok_timing: got timeout=%0d shape_ok=%0d expected 0/1", to, fok); errors++; end
    checks++; if (d[7:0] !== 8'h72) begin $display("FAIL cks_ok_byte: got %h expected 72", d[7:0]); errors++; end
    checks++; if (d !== 40'h5005_1A03_72) begin $display("FAIL cks_ok_data: got %h expected 50051a0372", d); errors++; end
    idle(5);
  endtask

  task automatic test_snapshot;
    logic [39:0] d; bit fok, ook, to;
    umidade = 16'h3C00; temperatura = 16'h1900; injeta = 1'b0;
    host_start(20);
    capture(5, d, fok, ook, to);
    checks++; if (temperatura !== 16'hFFFF) begin $display("FAIL snap_stimulus: got %h expected ffff", temperatura); errors++; end
    checks++; if (to || !fok) begin $display("FAIL snap_timing: got timeout=%0d shape_ok=%0d expected 0/1", to, fok); errors++; end
    checks++; if (d !== 40'h3C00_1900_55) begin $display("FAIL snap_data: got %h expected 3c00190055", d); errors++; end
    temperatura = 16'h1900;
    idle(5);
  endtask

  task automatic test_reset_mid_frame;
    logic [39:0] d; bit fok, ook, to; int k;
    umidade = 16'h3C00; temperatura = 16'h1900; injeta = 1'b0;
    host_start(20);
    k = 0;
    while (db_estado !== 4'd6 && k < 300) begin @(negedge clock); k++; end
    checks++; if (db_estado !== 4'd6) begin $display("FAIL rst_mid_reach: got estado %0d expected 6", db_estado); errors++; end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (puxa !== 1'b0) begin $display("FAIL rst_mid_puxa: got %b expected 0", puxa); errors++; end
    checks++; if (ocupado !== 1'b0) begin $display("FAIL rst_mid_ocupado: got %b expected 0", ocupado); errors++; end
    checks++; if (db_estado !== 4'd0) begin $display("FAIL rst_mid_estado: got %0d expected 0", db_estado); errors++; end
    @(negedge clock);
    reset = 1'b0;
    idle(5);
    host_start(20);
    capture(-1, d, fok, ook, to);
    checks++; if (to || !fok) begin $display("FAIL rst_after_timing: got timeout=%0d shape_ok=%0d expected 0/1", to, fok); errors++; end
    checks++; if (d !== 40'h3C00_1900_55) begin $display("FAIL rst_after_data: got %h expected 3c00190055", d); errors++; end
    idle(5);
  endtask

  task automatic test_habilita;
    logic [39:0] d; bit fok, ook, to; int np, npr, noc;
    umidade = 16'h3C00; temperatura = 16'h1900; injeta = 1'b0;
    habilita = 1'b0;
    host_start(20);
    observe(100, np, npr, noc);
    checks++; if (np != 0 || noc != 0) begin $display("FAIL hab0_response: got puxa=%0d ocupado=%0d expected 0", np, noc); errors++; end
    checks++; if (npr != 0) begin $display("FAIL hab0_pronto: got %0d expected 0", npr); errors++; end
    habilita = 1'b1;
    host_start(20);
    capture(-1, d, fok, ook, to);
    checks++; if (to || !fok) begin $display("FAIL hab1_timing: got timeout=%0d shape_ok=%0d expected 0/1", to, fok); errors++; end
    checks++; if (d !== 40'h3C00_1900_55) begin $display("FAIL hab1_data: got %h expected 3c00190055", d); errors++; end
    idle(5);
  endtask

  task automatic test_back_to_back;
    logic [39:0] d1, d2; bit f1, o1, t1, f2, o2, t2; int np, npr, noc;
    umidade = 16'h3C00; temperatura = 16'h1900; injeta = 1'b0;
    host_start(20);
    capture(-1, d1, f1, o1, t1);
    umidade = 16'h5005; temperatura = 16'h1A03;
    idle(3);
    host_start(20);
    capture(-1, d2, f2, o2, t2);
    checks++; if (t1 || !f1) begin $display("FAIL b2b_first_timing: got timeout=%0d shape_ok=%0d expected 0/1", t1, f1); errors++; end
    checks++; if (d1 !== 40'h3C00_1900_55) begin $display("FAIL b2b_first_data: got %h expected 3c00190055", d1); errors++; end
    checks++; if (t2 || !f2) begin $display("FAIL b2b_second_timing: got timeout=%0d shape_ok=%0d expected 0/1", t2, f2); errors++; end
    checks++; if (d2 !== 40'h5005_1A03_72) begin $display("FAIL b2b_second_data: got %h expected 50051a0372", d2); errors++; end
    checks++; if (!o1 || !o2) begin $display("FAIL b2b_ocupado: got ok=%0d/%0d expected 1/1", o1, o2); errors++; end
    observe(30, np, npr, noc);
    checks++; if (npr != 0 || np != 0) begin $display("FAIL b2b_after: got pronto=%0d puxa=%0d expected 0/0", npr, np); errors++; end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_start();
    test_checksum();
    test_snapshot();
    test_reset_mid_frame();
    test_habilita();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
